// File: rtl/scratch_mem_responder.sv
// scratch_mem_responder: shared single-port 19-bit scratch memory serving two
// requester ports through an arbiter, with out-of-window access flagging.
// Build option: SCRATCH_RR_ARB_EN selects round-robin tie-break; undefined
// gives fixed priority to p0.
module scratch_mem_responder #(
    parameter int unsigned DEPTH = 1024,
    parameter logic [18:0] BASE  = 19'h04000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        p0_valid,
    input  logic        p0_write,
    input  logic [18:0] p0_addr,
    input  logic [18:0] p0_wdata,
    output logic        p0_ready,
    output logic        p0_rvalid,
    output logic [18:0] p0_rdata,
    output logic        p0_err,
    input  logic        p1_valid,
    input  logic        p1_write,
    input  logic [18:0] p1_addr,
    input  logic [18:0] p1_wdata,
    output logic        p1_ready,
    output logic        p1_rvalid,
    output logic [18:0] p1_rdata,
    output logic        p1_err
);

    localparam int unsigned DW = 19;
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DW-1:0] mem [DEPTH];

    logic          p1_wins_tie;
    logic          grant1;
    logic          acc;
    logic          sel_write;
    logic [DW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    logic          in_range;
    logic [AW-1:0] idx;

`ifdef SCRATCH_RR_ARB_EN
    typedef enum logic {G0 = 1'b0, G1 = 1'b1} grant_e;
    grant_e last_grant, last_grant_nxt;

    // Arbiter state register; G1 after reset so p0 wins the first tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last_grant <= G1;
        else        last_grant <= last_grant_nxt;
    end

    // Next grant history and tie-break decision
    always_comb begin
        last_grant_nxt = last_grant;
        p1_wins_tie    = (last_grant == G0);
        if (acc) last_grant_nxt = grant1 ? G1 : G0;
    end
`else
    // Fixed priority: p0 always wins a tie
    always_comb begin
        p1_wins_tie = 1'b0;
    end
`endif

    // Grants, request mux and window decode
    always_comb begin
        p0_ready  = p0_valid && !(p1_valid && p1_wins_tie);
        p1_ready  = p1_valid && (!p0_valid || p1_wins_tie);
        grant1    = p1_valid && p1_ready;
        acc       = (p0_valid && p0_ready) || grant1;
        sel_write = grant1 ? p1_write : p0_write;
        sel_addr  = grant1 ? p1_addr  : p0_addr;
        sel_wdata = grant1 ? p1_wdata : p0_wdata;
        in_range  = ({1'b0, sel_addr} >= {1'b0, BASE}) &&
                    ({1'b0, sel_addr} < (20'(BASE) + 20'(DEPTH)));
        idx       = AW'(sel_addr - BASE);
    end

    // Array write at the end of the accept cycle; storage is not reset
    always_ff @(posedge clk) begin
        if (acc && sel_write && in_range) mem[idx] <= sel_wdata;
    end

    // Registered responses routed back to the granted port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p0_rvalid <= 1'b0;
            p0_err    <= 1'b0;
            p0_rdata  <= '0;
            p1_rvalid <= 1'b0;
            p1_err    <= 1'b0;
            p1_rdata  <= '0;
        end else begin
            p0_rvalid <= acc && !grant1 && !sel_write;
            p0_err    <= acc && !grant1 && !in_range;
            p0_rdata  <= (acc && !grant1 && !sel_write && in_range) ? mem[idx] : '0;
            p1_rvalid <= acc && grant1 && !sel_write;
            p1_err    <= acc && grant1 && !in_range;
            p1_rdata  <= (acc && grant1 && !sel_write && in_range) ? mem[idx] : '0;
        end
    end

endmodule

// File: doc/scratch_mem_responder.md
# scratch_mem_responder

Shared word-addressed scratch memory that answers load/store requests from the SoC's accelerators: the FFT and crypto engines. It is the responder end of the accelerators' `mem_valid`/`mem_write`/`mem_addr`/`mem_wdata`/`mem_rdata` request interface, extended with a ready/rvalid handshake. Two requester ports share one single-port 19-bit array through an arbiter. Out-of-window accesses are flagged rather than aliased.

## Interface
- `DEPTH`, default 1024: number of 19-bit words; power of two, at least 2.
- `BASE`, default 19'h04000: first byte-free word address of the window; aligned to DEPTH.
- `clk`  in  1  clock; all logic on the rising edge.
- `rst_n`  in  1  reset: rst_n, asynchronous, active-low; clock clk.
- `p0_valid` / `p1_valid`  in  1  request present; held until accepted.
- `p0_write` / `p1_write`  in  1  1 = store, 0 = load.
- `p0_addr` / `p1_addr`  in  19  word address.
- `p0_wdata` / `p1_wdata`  in  19  store data.
- `p0_ready` / `p1_ready`  out  1  grant; the request is accepted when valid && ready. Combinational.
- `p0_rvalid` / `p1_rvalid`  out  1  one-cycle pulse carrying load response.
- `p0_rdata` / `p1_rdata`  out  19  load data; valid only with rvalid, else 0.
- `p0_err` / `p1_err`  out  1  one-cycle pulse: the accepted access was out of window.

## Operation
- Array `DEPTH` x 19 bits, not reset. The array performs one access per cycle.
- Index = (addr − BASE)[log2(DEPTH)−1:0].
- An access is in range iff BASE ≤ addr < BASE + DEPTH, compared as 19-bit unsigned values. BASE + DEPTH never exceeds 2^19.
- Arbiter state `last_grant` ∈ {G0, G1}, 1 bit:
  - Only one port valid: that port gets ready.
  - Both ports valid: the port not equal to `last_grant` gets ready; the other port's ready = 0.
  - Neither port valid: both readies = 0.
  - On acceptance, `last_grant` ← the granted port. With no acceptance it holds.
- Accepted in-range store: the array is written at the end of the accept cycle. No rvalid is produced.
- Accepted in-range load: rdata/rvalid are driven on the granted port the next cycle.
- Accepted out-of-range store: dropped, array unchanged; err pulses the next cycle.
- Accepted out-of-range load: the next cycle gives rvalid = 1, rdata = 0, err = 1.
- Requesters must hold addr/write/wdata stable while valid && !ready. The responder does not check this.

## Timing
- Accept in cycle N; the response (rvalid/rdata/err) appears in cycle N+1, registered.
- Throughput: one accepted request per cycle total. Back-to-back loads from one port with no bubbles.
- Read-after-write: a store accepted in N followed by a load of the same address accepted in N+1 returns the new data in N+2.
- A store and a load cannot collide in one cycle because there is a single grant.
- Reset values:
  - `last_grant` = G1, so p0 wins the first tie.
  - All rvalid/err = 0; all rdata = 0.
  - Ready is combinational from the valids, so it is 0 while the valids are 0.
- Reset asserted mid-operation: any pending response is discarded (no rvalid/err after release). Array contents are undefined-but-retained.
- p0 and p1 responses never assert in the same cycle.

## Configuration
- `SCRATCH_RR_ARB_EN` defined: round-robin tie-break via `last_grant`, as above.
- Not defined: fixed priority. On a tie p0 always gets ready; p1 is served only when p0_valid = 0. `last_grant` is not implemented.
- All other behaviour is identical in both builds.

## Test plan
- **Store/load:** p0 store 19'h5A5A5 to 19'h04005, then p0 load 19'h04005 → p1 silent; p0_rvalid = 1 and p0_rdata = 19'h5A5A5 exactly one cycle after the load's accept cycle.
- **Round-robin contention (macro on):** both ports hold loads for 4 cycles, p0→19'h04001 (data 19'h00011), p1→19'h04002 (data 19'h00022). Grants go p0, p1, p0, p1; rvalids alternate one cycle later with the matching data.
- **Fixed priority (macro off):** the same stimulus → p0_ready = 1 all 4 cycles and p1_ready = 0. p1 is accepted in the first cycle after p0_valid drops.
- **Out of window:**
  - p1 load 19'h04400 → next cycle p1_rvalid = 1, p1_rdata = 0, p1_err = 1.
  - p1 store 19'h7FFFF to 19'h03FFF → p1_err pulse, no rvalid. A subsequent load of 19'h043FF returns its prior value.
- **Read-after-write:** p0 store 19'h12345 to 19'h043FF in cycle N, p0 load of the same address in N+1 → p0_rdata = 19'h12345 in N+2.
- **Reset mid-op:** a load is accepted, then rst_n goes low in the next cycle → rvalid stays 0 after release. The first tie after release grants p0.
